lsu_ctrl: RTL and testbench

Load/store control stage between execute and the data memory block. It accepts one memory request from execute and forms the effective address. It checks alignment and width, then drives the data memory read/write ports for exactly one cycle. For loads it captures the returned raw word and does byte/half selection and sign/zero extension itself. The result goes back to writeback as a one-cycle response, and the pipeline is stalled while a request is in flight.

---
 rtl/lsu_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store control stage: forms the effective address, validates width and alignment,
// drives a single-cycle data-memory access and returns an extended load result to writeback.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [31:0]       req_store_data,
  input  logic [RD_W-1:0]   req_rd,
  output logic [2:0]        mem_load_type,
  output logic [2:0]        mem_store_type,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic              resp_is_load,
  output logic [RD_W-1:0]   resp_rd,
  output logic [31:0]       resp_data,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr,
  output logic              stall
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_EXC   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                is_load_q, is_load_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [2:0]          mem_load_type_q, mem_load_type_d;
  logic [2:0]          mem_store_type_q, mem_store_type_d;
  logic                mem_read_en_q, mem_read_en_d;
  logic                mem_write_en_q, mem_write_en_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_is_load_q, resp_is_load_d;
  logic [RD_W-1:0]     resp_rd_q, resp_rd_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                exc_valid_q, exc_valid_d;
  logic [1:0]          exc_cause_q, exc_cause_d;
  logic [ADDR_W-1:0]   exc_addr_q, exc_addr_d;
  logic [ADDR_W-1:0]   eff_addr_s;
  logic [1:0]          req_cause_s;

  // Returns 00 for a legal request, otherwise the exception cause code.
  function automatic logic [1:0] check_req(input logic ld, input logic st,
                                           input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] cause;
    cause = 2'b00;
    if (ld && st) begin
      cause = 2'b11;
    end else if (ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) begin
      cause = 2'b11;
    end else if (st && (f3 >= 3'b011)) begin
      cause = 2'b11;
    end else if ((f3[1:0] == 2'b01 && lo[0] != 1'b0) ||
                 (f3[1:0] == 2'b10 && lo != 2'b00)) begin
      cause = ld ? 2'b01 : 2'b10;
    end else begin
      cause = 2'b00;
    end
    return cause;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = word;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  assign eff_addr_s  = req_base + req_offset;
  assign req_cause_s = check_req(req_is_load, req_is_store, req_funct3, eff_addr_s[1:0]);

  always_comb begin
    state_d          = state_q;
    funct3_d         = funct3_q;
    is_load_d        = is_load_q;
    rd_d             = rd_q;
    mem_load_type_d  = mem_load_type_q;
    mem_store_type_d = mem_store_type_q;
    mem_read_en_d    = 1'b0;
    mem_write_en_d   = 1'b0;
    mem_address_d    = mem_address_q;
    mem_wdata_d      = mem_wdata_q;
    resp_valid_d     = 1'b0;
    resp_is_load_d   = resp_is_load_q;
    resp_rd_d        = resp_rd_q;
    resp_data_d      = resp_data_q;
    exc_valid_d      = 1'b0;
    exc_cause_d      = exc_cause_q;
    exc_addr_d       = exc_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && (req_is_load || req_is_store)) begin
          funct3_d  = req_funct3;
          is_load_d = req_is_load;
          rd_d      = req_rd;
          if (req_cause_s != 2'b00) begin
            exc_valid_d = 1'b1;
            exc_cause_d = req_cause_s;
            exc_addr_d  = eff_addr_s;
            state_d     = S_EXC;
          end else if (req_is_load) begin
            // The full word is always fetched; lane selection happens here on return.
            mem_address_d   = eff_addr_s;
            mem_read_en_d   = 1'b1;
            mem_load_type_d = 3'b010;
            state_d         = S_ISSUE;
          end else begin
            mem_address_d    = eff_addr_s;
            mem_write_en_d   = 1'b1;
            mem_store_type_d = req_funct3;
            mem_wdata_d      = req_store_data;
            state_d          = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        resp_valid_d   = 1'b1;
        resp_is_load_d = is_load_q;
        resp_rd_d      = rd_q;
        resp_data_d    = is_load_q ? extract(mem_rdata, funct3_q, mem_address_q[1:0])
                                   : 32'h00000000;
        state_d        = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      funct3_q         <= 3'b000;
      is_load_q        <= 1'b0;
      rd_q             <= '0;
      mem_load_type_q  <= 3'b000;
      mem_store_type_q <= 3'b000;
      mem_read_en_q    <= 1'b0;
      mem_write_en_q   <= 1'b0;
      mem_address_q    <= '0;
      mem_wdata_q      <= 32'h00000000;
      resp_valid_q     <= 1'b0;
      resp_is_load_q   <= 1'b0;
      resp_rd_q        <= '0;
      resp_data_q      <= 32'h00000000;
      exc_valid_q      <= 1'b0;
      exc_cause_q      <= 2'b00;
      exc_addr_q       <= '0;
    end else begin
      state_q          <= state_d;
      funct3_q         <= funct3_d;
      is_load_q        <= is_load_d;
      rd_q             <= rd_d;
      mem_load_type_q  <= mem_load_type_d;
      mem_store_type_q <= mem_store_type_d;
      mem_read_en_q    <= mem_read_en_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_address_q    <= mem_address_d;
      mem_wdata_q      <= mem_wdata_d;
      resp_valid_q     <= resp_valid_d;
      resp_is_load_q   <= resp_is_load_d;
      resp_rd_q        <= resp_rd_d;
      resp_data_q      <= resp_data_d;
      exc_valid_q      <= exc_valid_d;
      exc_cause_q      <= exc_cause_d;
      exc_addr_q       <= exc_addr_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE) && !rst;
  assign stall          = (state_q != S_IDLE);
  assign mem_load_type  = mem_load_type_q;
  assign mem_store_type = mem_store_type_q;
  assign mem_read_en    = mem_read_en_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_address    = mem_address_q;
  assign mem_wdata      = mem_wdata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_is_load   = resp_is_load_q;
  assign resp_rd        = resp_rd_q;
  assign resp_data      = resp_data_q;
  assign exc_valid      = exc_valid_q;
  assign exc_cause      = exc_cause_q;
  assign exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized requests checked
// against a byte-array reference model, with a simple registered data-memory stub.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_store_data;
  logic [4:0]  req_rd;
  logic [2:0]  mem_load_type, mem_store_type;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        resp_valid, resp_is_load;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        stall;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] stub_mem [0:255];
  logic [7:0] ref_mem  [0:255];

  lsu_ctrl #(.ADDR_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_base(req_base), .req_offset(req_offset), .req_store_data(req_store_data),
    .req_rd(req_rd), .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .resp_is_load(resp_is_load), .resp_rd(resp_rd), .resp_data(resp_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr), .stall(stall)
  );

  always #5 clk = ~clk;

  // Data memory stub: places store data by type, returns the aligned word one cycle later.
  always @(posedge clk) begin
    if (mem_write_en) begin
      case (mem_store_type)
        3'b000: stub_mem[mem_address[7:0]] = mem_wdata[7:0];
        3'b001: begin
          stub_mem[{mem_address[7:1], 1'b0}] = mem_wdata[7:0];
          stub_mem[{mem_address[7:1], 1'b1}] = mem_wdata[15:8];
        end
        default: begin
          stub_mem[{mem_address[7:2], 2'b00}] = mem_wdata[7:0];
          stub_mem[{mem_address[7:2], 2'b01}] = mem_wdata[15:8];
          stub_mem[{mem_address[7:2], 2'b10}] = mem_wdata[23:16];
          stub_mem[{mem_address[7:2], 2'b11}] = mem_wdata[31:24];
        end
      endcase
    end
    if (mem_read_en)
      mem_rdata <= {stub_mem[{mem_address[7:2], 2'b11}], stub_mem[{mem_address[7:2], 2'b10}],
                    stub_mem[{mem_address[7:2], 2'b01}], stub_mem[{mem_address[7:2], 2'b00}]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [1:0] model_cause(input bit ld, input bit st, input int f3,
                                             input logic [31:0] a);
    int sz;
    if (ld && st) return 2'b11;
    if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 2'b11;
    if (st && f3 > 2) return 2'b11;
    sz = 1 << (f3 % 4);
    if ((a % sz) != 0) return ld ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input logic [31:0] a);
    int base4;
    logic [31:0] word, v;
    base4 = int'(a % 256) & ~3;
    word = {ref_mem[base4 + 3], ref_mem[base4 + 2], ref_mem[base4 + 1], ref_mem[base4]};
    v = word >> (8 * (a % 4));
    case (f3)
      0: begin v = v & 32'h000000FF; if (v[7])  v = v | 32'hFFFFFF00; end
      4: v = v & 32'h000000FF;
      1: begin v = v & 32'h0000FFFF; if (v[15]) v = v | 32'hFFFF0000; end
      5: v = v & 32'h0000FFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic model_store(input int f3, input logic [31:0] a, input logic [31:0] d);
    int nbytes;
    nbytes = 1 << f3;
    for (int i = 0; i < nbytes; i++) ref_mem[(a + i) % 256] = d[8*i +: 8];
  endtask

  // Issues one request from IDLE and checks every cycle until the stage is ready again.
  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] data, input logic [4:0] rd);
    logic [31:0] a;
    logic [1:0]  cause;
    a = base + off;
    cause = model_cause(ld, st, int'(f3), a);
    check("ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_store_data = data; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (cause != 2'b00) begin
      check("exc_valid", {31'd0, exc_valid}, 32'd1);
      check("exc_cause", {30'd0, exc_cause}, {30'd0, cause});
      check("exc_addr", exc_addr, a);
      check("exc_no_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
      check("exc_no_resp", {31'd0, resp_valid}, 32'd0);
      check("exc_stall", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      check("exc_pulse_end", {30'd0, exc_valid, resp_valid}, 32'd0);
      check("exc_ready_again", {31'd0, req_ready}, 32'd1);
    end else begin
      check("issue_en", {30'd0, mem_read_en, mem_write_en}, ld ? 32'd2 : 32'd1);
      check("issue_addr", mem_address, a);
      check("issue_stall", {31'd0, stall}, 32'd1);
      if (ld) check("issue_ltype", {29'd0, mem_load_type}, 32'd2);
      else begin
        check("issue_stype", {29'd0, mem_store_type}, {29'd0, f3});
        check("issue_wdata", mem_wdata, data);
        model_store(int'(f3), a, data);
      end
      @(posedge clk); #1;
      check("wait_en_low", {30'd0, mem_read_en, mem_write_en}, 32'd0);
      check("wait_no_resp", {31'd0, resp_valid}, 32'd0);
      check("wait_addr_hold", mem_address, a);
      @(posedge clk); #1;
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_no_exc", {31'd0, exc_valid}, 32'd0);
      check("resp_is_load", {31'd0, resp_is_load}, {31'd0, ld});
      check("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
      check("resp_data", resp_data, ld ? model_load(int'(f3), a) : 32'd0);
      @(posedge clk); #1;
      check("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
      check("ready_again", {30'd0, req_ready, stall}, 32'd2);
    end
  endtask

  initial begin
    int k;
    logic [2:0] f3;
    bit ld, st;
    for (int i = 0; i < 256; i++) begin stub_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'b000; req_base = 32'd0; req_offset = 32'd0;
    req_store_data = 32'd0; req_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {mem_load_type, mem_store_type, mem_read_en, mem_write_en,
          resp_valid, resp_is_load, resp_rd, exc_valid, exc_cause, 12'd0}, 32'd0);
    check("reset_wide", mem_address | mem_wdata | resp_data | exc_addr, 32'd0);
    check("reset_ready_low", {30'd0, req_ready, stall}, 32'd0);
    rst = 1'b0;
    #1 check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    do_req(1'b0, 1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd0);
    do_req(1'b1, 1'b0, 3'b000, 32'h107, 32'h0, 32'h0, 5'd3);
    check("lb_value", resp_data, 32'hFFFFFFDE);
    do_req(1'b1, 1'b0, 3'b100, 32'h107, 32'h0, 32'h0, 5'd4);
    check("lbu_value", resp_data, 32'h000000DE);
    do_req(1'b1, 1'b0, 3'b001, 32'h100, 32'h4, 32'h0, 5'd5);
    check("lh_value", resp_data, 32'hFFFFBEEF);
    do_req(1'b1, 1'b0, 3'b101, 32'h106, 32'h0, 32'h0, 5'd6);
    check("lhu_value", resp_data, 32'h0000DEAD);
    do_req(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 5'd31);
    check("lw_value", resp_data, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 5'd1);
    check("exc_lw_cause", {30'd0, exc_cause}, 32'd1);
    do_req(1'b0, 1'b1, 3'b001, 32'h103, 32'h0, 32'h1234, 5'd1);
    check("exc_sh_cause", {30'd0, exc_cause}, 32'd2);
    do_req(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd1);
    check("exc_f3_cause", {30'd0, exc_cause}, 32'd3);
    do_req(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 5'd1);
    do_req(1'b1, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd2);
    check("wrap_addr", mem_address, 32'h00000004);
    do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFC, 32'hCAFEF00D, 5'd2);
    check("neg_off_addr", mem_address, 32'h0000000C);

    // Requests with neither flag set are ignored.
    req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ignore_state", {29'd0, req_ready, stall, mem_read_en | mem_write_en}, 32'd4);
    end
    req_valid = 1'b0;

    // Back-to-back: one accept every four cycles while req_valid stays high.
    req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h100; req_offset = 32'h0;
    for (int i = 0; i < 9; i++) begin
      check("b2b_ready", {31'd0, req_ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
      check("b2b_stall", {31'd0, stall}, (i % 4 == 0) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    k = 0;
    while (!req_ready && k < 8) begin @(posedge clk); #1; k++; end
    check("drain_ready", {31'd0, req_ready}, 32'd1);

    // Reset during WAIT of a load drops the transaction.
    req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_base = 32'h104; req_offset = 32'h0; req_rd = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_wait", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_no_resp", {30'd0, resp_valid, exc_valid}, 32'd0);
    check("rst_outputs", {mem_load_type, mem_store_type, mem_read_en, mem_write_en,
          resp_is_load, resp_rd, exc_cause, stall, 12'd0}, 32'd0);
    check("rst_wide", mem_address | mem_wdata | resp_data | exc_addr, 32'd0);
    rst = 1'b0;
    #1 check("rst_ready_after", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check("rst_still_no_resp", {30'd0, resp_valid, stall}, 32'd0);

    for (int n = 0; n < 60; n++) begin
      ld = ($urandom_range(0, 1) == 1);
      st = !ld || ($urandom_range(0, 15) == 0);
      f3 = 3'($urandom_range(0, 7));
      do_req(ld, st, f3, 32'h100 + 32'($urandom_range(0, 31)),
             32'($urandom_range(0, 15)) - 32'd8, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
